fifo_flex: RTL and testbench
============================

Name: fifo_flex

Overview:
Parametrised next-generation synchronous FIFO for the verification codebase. It generalises the basic 8x16 FIFO in width, depth and read mode. It adds an occupancy count, programmable almost-full/almost-empty thresholds and an optional first-word-fall-through (FWFT) read mode. It is a single-clock buffer between a producer and a consumer, both using the same valid-style enables.

Parameters:
DATA_WIDTH, 8, width of each stored word (1..256)
DEPTH, 16, number of entries; must be a power of two and >= 2; elaboration error otherwise
AF_THRESH, DEPTH-2, almost_full asserts when count >= AF_THRESH; legal range 1..DEPTH
AE_THRESH, 2, almost_empty asserts when count <= AE_THRESH; legal range 0..DEPTH-1
FWFT, 0, 0 = registered read (data one cycle after rd_en); 1 = first-word-fall-through

Ports:
clk  in  1  clock; all state updates on the rising edge
rst_n  in  1  asynchronous reset, active-low
wr_en  in  1  write request
wr_data  in  DATA_WIDTH  write data
full  out  1  FIFO holds DEPTH words
almost_full  out  1  count >= AF_THRESH
rd_en  in  1  read (pop) request
rd_data  out  DATA_WIDTH  read data
empty  out  1  FIFO holds 0 words
almost_empty  out  1  count <= AE_THRESH
count  out  $clog2(DEPTH+1)  current occupancy, 0..DEPTH

Behaviour:
- Reset (asynchronous, rst_n=0) immediately sets:
  - wr_ptr=0, rd_ptr=0, count=0
  - empty=1, full=0, almost_empty=1, almost_full=0
  - rd_data=0
  - Memory contents are not reset.
- Reset can assert at any time, including mid-burst; all in-flight state is discarded. The first access after deassertion behaves as on an empty FIFO.
- Write acceptance: wr_acc = wr_en && !full.
  - When full, a write is dropped even if a read occurs in the same cycle. There is no pass-through.
  - An accepted write stores wr_data at mem[wr_ptr] and increments wr_ptr modulo DEPTH.
- Read acceptance: rd_acc = rd_en && !empty.
  - When empty, a read is ignored, even if a write occurs in the same cycle.
  - An accepted read increments rd_ptr modulo DEPTH.
- Count update: count_next = count + wr_acc - rd_acc.
  - A simultaneous accepted write and read leaves count unchanged.
  - Pointers wrap naturally at DEPTH (log2(DEPTH)-bit pointers).
- All flags are registered and derived from count_next, so they are valid in the same cycle as count:
  - empty = (count==0)
  - full = (count==DEPTH)
  - almost_full = (count>=AF_THRESH)
  - almost_empty = (count<=AE_THRESH)
- FWFT=0:
  - rd_data is registered and loads mem[rd_ptr] on the rising edge where rd_acc=1, so it is valid 1 cycle after rd_en is sampled.
  - rd_data holds its value when no read is accepted.
- FWFT=1:
  - rd_data = mem[rd_ptr] combinationally whenever empty=0. It shows the head word with 0-cycle latency.
  - rd_en acknowledges (pops) that word.
  - When empty=1, rd_data holds the last value driven, or 0 after reset.
  - A write into an empty FIFO makes the word visible the cycle after the write edge, when empty falls.

Optional Feature:
Macro FIFO_FLEX_ERR_STICKY_EN.
- Defined:
  - Adds input err_clr (1) and outputs overflow (1) and underflow (1). All reset to 0.
  - overflow is set on any cycle with wr_en && full.
  - underflow is set on any cycle with rd_en && empty.
  - Both flags stay set until an err_clr pulse. Set has priority over a same-cycle err_clr.
- Not defined: these ports and their logic are absent; rejected accesses are silently dropped.

Decomposition:
- Package fifo_flex_pkg holds:
  - function fifo_cnt_w(depth) returning $clog2(depth+1)
  - function is_pow2(depth), used for the parameter check
  - localparam defaults DEF_DATA_WIDTH=8 and DEF_DEPTH=16
- Sub-module fifo_flex_mem: a simple dual-port array.
  - Write port: clock, enable, address, data.
  - Read port: asynchronous address-to-data.
  - The top level owns pointers, count, flags and the rd_data register.

Test Plan (DATA_WIDTH=8, DEPTH=16, AF_THRESH=14, AE_THRESH=2):
- After reset, write 0..4 then read 5 times (FWFT=0) -> rd_data 0,1,2,3,4, each 1 cycle after its rd_en. count 5->0. empty=1 at end.
- Write 16 random words, then attempt a 17th -> full=1, count=16, almost_full asserted from count=14. The 17th word is dropped; a drain returns the original 16 in order.
- Full FIFO with simultaneous wr_en and rd_en -> only the read is accepted, count=15. Empty FIFO with both -> only the write is accepted, count=1.
- Write 20 and read 20 across the pointer wrap with interleaved simultaneous accesses -> data matches the queue model and count stays consistent. almost_empty toggles at count 2/3.
- FWFT=1: write 0xA5 into an empty FIFO -> rd_data=0xA5 with empty=0 on the next cycle, before any rd_en. Pulse rd_en -> empty=1.
- Assert rst_n=0 mid-burst with count=9 -> outputs reset immediately (count=0, empty=1, rd_data=0). With FIFO_FLEX_ERR_STICKY_EN defined, a read while empty sets underflow, which stays set until err_clr.

Source files
------------

// File: rtl/fifo_flex_pkg.sv
// fifo_flex_pkg: shared defaults and elaboration-time helpers for fifo_flex.
package fifo_flex_pkg;

    localparam int DEF_DATA_WIDTH = 8;
    localparam int DEF_DEPTH      = 16;

    // Width of an occupancy counter that must represent 0..depth inclusive.
    function automatic int fifo_cnt_w(input int depth);
        return $clog2(depth + 1);
    endfunction

    // True when depth is a non-zero power of two.
    function automatic bit is_pow2(input int depth);
        return (depth > 0) && ((depth & (depth - 1)) == 0);
    endfunction

endpackage

// File: rtl/fifo_flex_mem.sv
// fifo_flex_mem: simple dual-port storage array, synchronous write port and
// asynchronous (address-to-data) read port.
module fifo_flex_mem #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 16,
    parameter int ADDR_W     = 4
) (
    input  logic                  clk,
    input  logic                  wr_en,
    input  logic [ADDR_W-1:0]     wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic [ADDR_W-1:0]     rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data
);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    // Store the incoming word at the write address.
    // NOTE: storage is deliberately left out of reset; occupancy is tracked by
    // the pointers, so stale contents are never observed and the array can
    // map onto plain RAM without a reset network.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem_q[rd_addr];

endmodule

// File: rtl/fifo_flex.sv
// fifo_flex: parametrised single-clock FIFO with occupancy count, programmable
// almost-full/almost-empty thresholds and optional first-word-fall-through.
// Optional sticky error flags (err_clr, overflow, underflow) are built when the
// macro FIFO_FLEX_ERR_STICKY_EN is defined.
module fifo_flex
    import fifo_flex_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int DEPTH      = DEF_DEPTH,
    parameter int AF_THRESH  = DEPTH - 2,
    parameter int AE_THRESH  = 2,
    parameter int FWFT       = 0
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           wr_en,
    input  logic [DATA_WIDTH-1:0]          wr_data,
    output logic                           full,
    output logic                           almost_full,
    input  logic                           rd_en,
    output logic [DATA_WIDTH-1:0]          rd_data,
    output logic                           empty,
    output logic                           almost_empty,
    output logic [fifo_cnt_w(DEPTH)-1:0]   count
`ifdef FIFO_FLEX_ERR_STICKY_EN
    ,
    input  logic                           err_clr,
    output logic                           overflow,
    output logic                           underflow
`endif
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = fifo_cnt_w(DEPTH);

    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] AF_C    = CNT_W'(AF_THRESH);
    localparam logic [CNT_W-1:0] AE_C    = CNT_W'(AE_THRESH);

    if (!is_pow2(DEPTH) || DEPTH < 2) begin : g_bad_depth
        $error("fifo_flex: DEPTH must be a power of two and >= 2");
    end
    if (AF_THRESH < 1 || AF_THRESH > DEPTH) begin : g_bad_af
        $error("fifo_flex: AF_THRESH must be in 1..DEPTH");
    end
    if (AE_THRESH < 0 || AE_THRESH > DEPTH - 1) begin : g_bad_ae
        $error("fifo_flex: AE_THRESH must be in 0..DEPTH-1");
    end

    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic                  empty_q, full_q, af_q, ae_q;
    logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
    logic [DATA_WIDTH-1:0] mem_rd_data;
    logic                  wr_acc, rd_acc;

    fifo_flex_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH),
        .ADDR_W     (PTR_W)
    ) u_mem (
        .clk     (clk),
        .wr_en   (wr_acc),
        .wr_addr (wr_ptr_q),
        .wr_data (wr_data),
        .rd_addr (rd_ptr_q),
        .rd_data (mem_rd_data)
    );

    // Accept/reject decisions, next pointers, next count and next read word.
    // NOTE: every signal gets a default at the top of the block so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        wr_acc    = wr_en && !full_q;
        rd_acc    = rd_en && !empty_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        rd_data_d = rd_data_q;
        count_d   = count_q + CNT_W'(wr_acc) - CNT_W'(rd_acc);
        if (wr_acc) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (rd_acc) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        if (FWFT != 0) begin
            // Track the head word so it is still presented once the FIFO drains.
            if (!empty_q) begin
                rd_data_d = mem_rd_data;
            end
        end else if (rd_acc) begin
            rd_data_d = mem_rd_data;
        end
    end

    // Pointer, count, flag and read-data registers; flags follow count_d so they
    // change in the same cycle as count.
    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            empty_q   <= 1'b1;
            full_q    <= 1'b0;
            af_q      <= 1'b0;
            ae_q      <= 1'b1;
            rd_data_q <= '0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            empty_q   <= (count_d == '0);
            full_q    <= (count_d == DEPTH_C);
            af_q      <= (count_d >= AF_C);
            ae_q      <= (count_d <= AE_C);
            rd_data_q <= rd_data_d;
        end
    end

    assign full         = full_q;
    assign empty        = empty_q;
    assign almost_full  = af_q;
    assign almost_empty = ae_q;
    assign count        = count_q;
    assign rd_data      = ((FWFT != 0) && !empty_q) ? mem_rd_data : rd_data_q;

`ifdef FIFO_FLEX_ERR_STICKY_EN
    logic overflow_q, overflow_d;
    logic underflow_q, underflow_d;

    // Sticky error flags: a rejected access sets, err_clr clears, set wins.
    always_comb begin
        overflow_d  = overflow_q;
        underflow_d = underflow_q;
        if (err_clr) begin
            overflow_d  = 1'b0;
            underflow_d = 1'b0;
        end
        if (wr_en && full_q) begin
            overflow_d = 1'b1;
        end
        if (rd_en && empty_q) begin
            underflow_d = 1'b1;
        end
    end

    // Sticky error flag registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    assign overflow  = overflow_q;
    assign underflow = underflow_q;
`endif

endmodule

// File: tb/tb_fifo_flex.sv
// tb_fifo_flex: directed self-checking bench for fifo_flex (registered read
// instance plus a first-word-fall-through instance sharing clock and reset).
module tb_fifo_flex;

    logic       clk = 1'b0;
    logic       rst_n;

    logic       wr_en, rd_en;
    logic [7:0] wr_data, rd_data;
    logic       full, almost_full, empty, almost_empty;
    logic [4:0] count;

    logic       wr_en1, rd_en1;
    logic [7:0] wr_data1, rd_data1;
    logic       full1, almost_full1, empty1, almost_empty1;
    logic [4:0] count1;

`ifdef FIFO_FLEX_ERR_STICKY_EN
    logic       err_clr, overflow, underflow;
    logic       err_clr1, overflow1, underflow1;
`endif

    int         total = 0;
    int         bad   = 0;

    logic [7:0] words [16];
    logic [7:0] q [$];
    logic [7:0] exp_rd;
    logic       wacc, racc;
    int         nw, nr;

    fifo_flex #(.DATA_WIDTH(8), .DEPTH(16), .AF_THRESH(14), .AE_THRESH(2), .FWFT(0)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .wr_en        (wr_en),
        .wr_data      (wr_data),
        .full         (full),
        .almost_full  (almost_full),
        .rd_en        (rd_en),
        .rd_data      (rd_data),
        .empty        (empty),
        .almost_empty (almost_empty),
        .count        (count)
`ifdef FIFO_FLEX_ERR_STICKY_EN
        ,
        .err_clr      (err_clr),
        .overflow     (overflow),
        .underflow    (underflow)
`endif
    );

    fifo_flex #(.DATA_WIDTH(8), .DEPTH(16), .AF_THRESH(14), .AE_THRESH(2), .FWFT(1)) dut_fwft (
        .clk          (clk),
        .rst_n        (rst_n),
        .wr_en        (wr_en1),
        .wr_data      (wr_data1),
        .full         (full1),
        .almost_full  (almost_full1),
        .rd_en        (rd_en1),
        .rd_data      (rd_data1),
        .empty        (empty1),
        .almost_empty (almost_empty1),
        .count        (count1)
`ifdef FIFO_FLEX_ERR_STICKY_EN
        ,
        .err_clr      (err_clr1),
        .overflow     (overflow1),
        .underflow    (underflow1)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Advance one clock; outputs are then sampled 1 ns after the edge.
    task automatic step;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b1;
        wr_en = 0; rd_en = 0; wr_data = '0;
        wr_en1 = 0; rd_en1 = 0; wr_data1 = '0;
`ifdef FIFO_FLEX_ERR_STICKY_EN
        err_clr = 0; err_clr1 = 0;
`endif
        #2 rst_n = 1'b0;
        #1;
        // Asynchronous reset values, before any clock edge.
        check("rst_count", count, 0);
        check("rst_empty", empty, 1);
        check("rst_full", full, 0);
        check("rst_ae", almost_empty, 1);
        check("rst_af", almost_full, 0);
        check("rst_rd_data", rd_data, 0);
        check("rst_fwft_rd_data", rd_data1, 0);
        step;
        step;
        rst_n = 1'b1;

        // Basic write 0..4 then read 5 (registered read).
        for (int i = 0; i < 5; i++) begin
            wr_en = 1; wr_data = 8'(i);
            step;
        end
        wr_en = 0;
        check("t1_count5", count, 5);
        for (int i = 0; i < 5; i++) begin
            rd_en = 1;
            step;
            check("t1_rd_data", rd_data, i);
            check("t1_count", count, 4 - i);
        end
        rd_en = 0;
        step;
        check("t1_hold", rd_data, 4);
        check("t1_empty", empty, 1);

        // Fill with 16 random words, watch almost_full and full.
        for (int i = 0; i < 16; i++) begin
            words[i] = 8'($urandom_range(0, 255));
            wr_en = 1; wr_data = words[i];
            step;
            check("t2_af", almost_full, (i + 1) >= 14);
            check("t2_full", full, i == 15);
        end
        wr_data = ~words[0];
        step;
        wr_en = 0;
        check("t2_count17", count, 16);
        check("t2_full17", full, 1);

        // Full with simultaneous write and read: only the read is accepted.
        wr_en = 1; rd_en = 1; wr_data = 8'h5A;
        step;
        wr_en = 0;
        check("t3_full_both_count", count, 15);
        check("t3_full_both_data", rd_data, words[0]);
        check("t3_full_both_full", full, 0);
        for (int i = 1; i < 16; i++) begin
            step;
            check("t3_drain", rd_data, words[i]);
        end
        rd_en = 0;
        check("t3_drain_count", count, 0);
        check("t3_drain_empty", empty, 1);

        // Empty with simultaneous write and read: only the write is accepted.
        wr_en = 1; rd_en = 1; wr_data = 8'h3C;
        step;
        wr_en = 0; rd_en = 0;
        check("t3_empty_both_count", count, 1);
        check("t3_empty_both_hold", rd_data, words[15]);
        check("t3_empty_both_empty", empty, 0);
        rd_en = 1;
        step;
        rd_en = 0;
        check("t3_empty_both_data", rd_data, 8'h3C);
        check("t3_empty_both_count0", count, 0);

        // 20 writes / 20 reads across the pointer wrap against a queue model.
        nw = 0; nr = 0;
        for (int c = 0; c < 200 && nr < 20; c++) begin
            wr_en   = (nw < 20) && (c % 4 != 3);
            rd_en   = (c >= 2) && (c % 3 != 0);
            wr_data = 8'h40 + 8'(nw);
            wacc    = wr_en && (q.size() < 16);
            racc    = rd_en && (q.size() > 0);
            if (racc) begin
                exp_rd = q.pop_front();
                nr++;
            end
            if (wacc) begin
                q.push_back(wr_data);
                nw++;
            end
            step;
            if (racc) check("t4_data", rd_data, exp_rd);
            check("t4_count", count, q.size());
            check("t4_ae", almost_empty, q.size() <= 2);
        end
        wr_en = 0; rd_en = 0;
        check("t4_reads", nr, 20);
        check("t4_empty", empty, 1);

        // First-word-fall-through instance.
        wr_en1 = 1; wr_data1 = 8'hA5;
        step;
        wr_en1 = 0;
        check("t5_fwft_data", rd_data1, 8'hA5);
        check("t5_fwft_empty", empty1, 0);
        rd_en1 = 1;
        step;
        rd_en1 = 0;
        check("t5_fwft_pop_empty", empty1, 1);
        check("t5_fwft_pop_hold", rd_data1, 8'hA5);
        wr_en1 = 1; wr_data1 = 8'hB1;
        step;
        wr_data1 = 8'hC2;
        step;
        wr_en1 = 0;
        check("t5_fwft_head1", rd_data1, 8'hB1);
        rd_en1 = 1;
        step;
        rd_en1 = 0;
        check("t5_fwft_head2", rd_data1, 8'hC2);
        check("t5_fwft_count", count1, 1);

        // Mid-burst reset with count=9.
        for (int i = 0; i < 9; i++) begin
            wr_en = 1; wr_data = 8'h90 + 8'(i);
            step;
        end
        check("t6_count9", count, 9);
        rst_n = 1'b0;
        #1;
        check("t6_rst_count", count, 0);
        check("t6_rst_empty", empty, 1);
        check("t6_rst_rd_data", rd_data, 0);
        check("t6_rst_af", almost_full, 0);
        check("t6_rst_ae", almost_empty, 1);
        check("t6_rst_fwft_data", rd_data1, 0);
        wr_en = 0;
        step;
        rst_n = 1'b1;
        wr_en = 1; wr_data = 8'h77;
        step;
        wr_en = 0; rd_en = 1;
        step;
        rd_en = 0;
        check("t6_after_rst_data", rd_data, 8'h77);
        check("t6_after_rst_count", count, 0);

`ifdef FIFO_FLEX_ERR_STICKY_EN
        // Underflow is sticky until err_clr.
        check("t7_uf_init", underflow, 0);
        rd_en = 1;
        step;
        rd_en = 0;
        check("t7_uf_set", underflow, 1);
        step;
        check("t7_uf_stick", underflow, 1);
        check("t7_of_clear", overflow, 0);
        err_clr = 1;
        step;
        err_clr = 0;
        check("t7_uf_clr", underflow, 0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
